// File: rtl/delay_commutator_pkg.sv
// Shared constants for the N=128 MDC FFT datapath: lane width, FFT size and
// the delay depth used by each delay-commutator stage.
package delay_commutator_pkg;

  localparam int LANE_W     = 16;
  localparam int FFT_N      = 128;
  localparam int NUM_STAGES = $clog2(FFT_N) - 1;

  // Stage 0 commutates samples N/4 apart, each later stage halves the distance.
  function automatic int stage_nd(input int stage);
    return FFT_N >> (stage + 2);
  endfunction

endpackage

// File: rtl/delay_commutator_delay_line.sv
// W-bit, ND-deep shift chain that advances only on enabled cycles;
// q is the word accepted ND enables ago.
module en_delay_line #(
  parameter int ND = 4,
  parameter int W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [ND];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) sr_q[i] <= '0;
    end else if (en) begin
      sr_q[0] <= d;
      for (int i = 1; i < ND; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q = sr_q[ND-1];

endmodule

// File: rtl/delay_commutator.sv
// Delay-switch-delay commutator: pairs samples ND accepted samples apart
// onto the two output lanes, with a priming mask after reset or restart.
module delay_commutator
  import delay_commutator_pkg::*;
#(
  parameter int ND = 4,
  parameter int W  = LANE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_clr,
  input  logic         in_valid,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out
);

  localparam int CNT_W   = $clog2(2 * ND);
  localparam int PRIME_W = $clog2(ND + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_cur;
  logic [PRIME_W-1:0] prime_q, prime_d, prime_cur;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       a_out_q, a_out_d, b_out_q, b_out_d;
  logic [W-1:0]       ad, bot, top, bot_pre;
  logic               sel;

  // A restart makes the current sample k=0, so phase and priming start from zero now.
  assign cnt_cur   = in_clr ? '0 : cnt_q;
  assign prime_cur = in_clr ? '0 : prime_q;
  assign sel       = cnt_cur[CNT_W-1];

  assign top     = sel ? b_in : ad;
  assign bot_pre = sel ? ad   : b_in;

  en_delay_line #(.ND(ND), .W(W)) u_upper (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .d   (a_in),
    .q   (ad)
  );

  en_delay_line #(.ND(ND), .W(W)) u_lower (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .d   (bot_pre),
    .q   (bot)
  );

  always_comb begin
    cnt_d       = cnt_cur;
    prime_d     = prime_cur;
    out_valid_d = 1'b0;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    if (in_valid) begin
      cnt_d       = cnt_cur + CNT_W'(1);
      out_valid_d = (prime_cur == PRIME_W'(ND));
      if (prime_cur != PRIME_W'(ND)) prime_d = prime_cur + PRIME_W'(1);
      a_out_d     = top;
      b_out_d     = bot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      prime_q     <= '0;
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_out     = a_out_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_delay_commutator.sv
// Directed bench for delay_commutator at ND=2, ND=1 and ND=4 sharing one
// input stream; each scenario starts from a reset.
module tb_delay_commutator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        ov2, ov1, ov4;
  logic [15:0] a2, b2, a1, b1, a4, b4;

  int checks = 0;
  int errors = 0;

  // Hand-derived ND=2 outputs for k=0..7 (k<2 is primed away).
  logic [15:0] tab_a [8] = '{16'h0, 16'h0, 16'hB2, 16'hB3, 16'hA2, 16'hA3, 16'hB6, 16'hB7};
  logic [15:0] tab_b [8] = '{16'h0, 16'h0, 16'hB0, 16'hB1, 16'hA0, 16'hA1, 16'hB4, 16'hB5};
  logic [15:0] ra [64];
  logic [15:0] rb [64];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  delay_commutator #(.ND(2), .W(16)) dut2 (
    .clk(clk), .rst(rst), .in_clr(in_clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .out_valid(ov2), .a_out(a2), .b_out(b2));

  delay_commutator #(.ND(1), .W(16)) dut1 (
    .clk(clk), .rst(rst), .in_clr(in_clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .out_valid(ov1), .a_out(a1), .b_out(b1));

  delay_commutator #(.ND(4), .W(16)) dut4 (
    .clk(clk), .rst(rst), .in_clr(in_clr), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .out_valid(ov4), .a_out(a4), .b_out(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic clr, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = v;
    in_clr   = clr;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_clr   = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference rule for the ND=4 stream: sel=(k mod 8)>=4.
  function automatic logic [15:0] ref_bot_pre(input int j);
    return ((j % 8) >= 4) ? ra[j-4] : rb[j];
  endfunction

  initial begin
    logic [15:0] ea, eb;
    int k;

    // Reset state
    apply_reset();
    check("rst_ov2", {31'd0, ov2}, 32'd0);
    check("rst_ab2", {a2, b2}, 32'd0);
    check("rst_ov1", {31'd0, ov1}, 32'd0);
    check("rst_ab4", {a4, b4}, 32'd0);

    // ND=2 continuous stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
      check($sformatf("cont_ov_k%0d", i), {31'd0, ov2}, {31'd0, (i >= 2)});
      if (i >= 2) check($sformatf("cont_ab_k%0d", i), {a2, b2}, {tab_a[i], tab_b[i]});
    end

    // ND=2 with in_valid toggling: same sequence, idle cycles hold
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
      check($sformatf("tog_ov_k%0d", i), {31'd0, ov2}, {31'd0, (i >= 2)});
      if (i >= 2) check($sformatf("tog_ab_k%0d", i), {a2, b2}, {tab_a[i], tab_b[i]});
      drive(1'b0, 1'b0, 16'hFFFF, 16'hEEEE);
      check($sformatf("tog_idle_ov_k%0d", i), {31'd0, ov2}, 32'd0);
      if (i >= 2) check($sformatf("tog_hold_k%0d", i), {a2, b2}, {tab_a[i], tab_b[i]});
    end

    // ND=1 continuous: (B1,B0),(A1,A0),(B3,B2),(A3,A2),...
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
      check($sformatf("nd1_ov_k%0d", i), {31'd0, ov1}, {31'd0, (i >= 1)});
      if (i >= 1) begin
        if (i % 2 == 1) begin
          ea = 16'hB0 + 16'(i);
          eb = 16'hB0 + 16'(i - 1);
        end else begin
          ea = 16'hA0 + 16'(i - 1);
          eb = 16'hA0 + 16'(i - 2);
        end
        check($sformatf("nd1_ab_k%0d", i), {a1, b1}, {ea, eb});
      end
    end

    // ND=2 restart with in_clr on stream sample 5
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
    check("clr_pre_ov", {31'd0, ov2}, 32'd1);
    drive(1'b1, 1'b1, 16'hA5, 16'hB5);
    check("clr_k0_ov", {31'd0, ov2}, 32'd0);
    drive(1'b1, 1'b0, 16'hA6, 16'hB6);
    check("clr_k1_ov", {31'd0, ov2}, 32'd0);
    drive(1'b1, 1'b0, 16'hA7, 16'hB7);
    check("clr_k2_ov", {31'd0, ov2}, 32'd1);
    check("clr_k2_ab", {a2, b2}, {16'hB7, 16'hB5});
    drive(1'b1, 1'b0, 16'hA8, 16'hB8);
    check("clr_k3_ab", {a2, b2}, {16'hB8, 16'hB6});
    drive(1'b1, 1'b0, 16'hA9, 16'hB9);
    check("clr_k4_ab", {a2, b2}, {16'hA7, 16'hA5});

    // ND=2 asynchronous reset mid-cycle at k=3
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
    check("arst_before_ab", {a2, b2}, {16'hB3, 16'hB1});
    #2 rst = 1'b1;
    #1;
    check("arst_ov", {31'd0, ov2}, 32'd0);
    check("arst_ab", {a2, b2}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'hA0 + 16'(i), 16'hB0 + 16'(i));
      check($sformatf("arst_post_ov_k%0d", i), {31'd0, ov2}, {31'd0, (i >= 2)});
    end
    check("arst_post_ab", {a2, b2}, {16'hB2, 16'hB0});

    // ND=4 random stream with random idle gaps against the reference rule
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      ra[i] = 16'($urandom_range(0, 65535));
      rb[i] = 16'($urandom_range(0, 65535));
    end
    k = 0;
    while (k < 64) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        check($sformatf("rnd_idle_ov_k%0d", k), {31'd0, ov4}, 32'd0);
        if (exp_q.size() == 2) check($sformatf("rnd_hold_k%0d", k), {a4, b4}, {exp_q[0], exp_q[1]});
      end else begin
        drive(1'b1, 1'b0, ra[k], rb[k]);
        check($sformatf("rnd_ov_k%0d", k), {31'd0, ov4}, {31'd0, (k >= 4)});
        if (k >= 4) begin
          exp_q.delete();
          exp_q.push_back(((k % 8) >= 4) ? rb[k] : ra[k-4]);
          exp_q.push_back(ref_bot_pre(k - 4));
          check($sformatf("rnd_ab_k%0d", k), {a4, b4}, {exp_q[0], exp_q[1]});
        end
        k++;
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
